ram_responder: RTL and testbench



---
 rtl/ram_responder.sv | 163 ++++++++++++++++
 tb/tb_ram_responder.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/ram_responder.sv
// 256x8 single-clock RAM serving the CPU bus, with a byte-stream program loader,
// an optional power-on clear sweep and an independent registered debug read port.
module ram_responder #(
    parameter int ADDR_W         = 8,
    parameter int DATA_W         = 8,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic              clk_qzt,
    input  logic              reset,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              cpu_we,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_hold,
    input  logic              load_start,
    input  logic [ADDR_W-1:0] load_base,
    input  logic [ADDR_W:0]   load_len,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    output logic              load_ready,
    output logic              load_done,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] PTR_LAST = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] PTR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   REM_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   REM_ZERO = {(ADDR_W+1){1'b0}};

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_IDLE  = 2'd1,
        ST_LOAD  = 2'd2
    } state_t;

    state_t              state_q;
    logic [ADDR_W-1:0]   ptr_q;
    logic [ADDR_W:0]     remaining_q;
    logic                we_old_q;
    logic [DATA_W-1:0]   cpu_rdata_q;
    logic [DATA_W-1:0]   dbg_data_q;
    logic                load_done_q;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic                wr_en_s;
    logic [ADDR_W-1:0]   wr_addr_s;
    logic [DATA_W-1:0]   wr_data_s;

    assign cpu_hold   = (state_q != ST_IDLE);
    assign load_ready = (state_q == ST_LOAD);
    assign cpu_rdata  = cpu_rdata_q;
    assign dbg_data   = dbg_data_q;
    assign load_done  = load_done_q;

    // Single write port arbitration: clear sweep, loader, or edge-qualified CPU write.
    always_comb begin
        wr_en_s   = 1'b0;
        wr_addr_s = ptr_q;
        wr_data_s = {DATA_W{1'b0}};
        case (state_q)
            ST_CLEAR: begin
                wr_en_s   = 1'b1;
                wr_addr_s = ptr_q;
                wr_data_s = {DATA_W{1'b0}};
            end
            ST_IDLE: begin
                // A pending load start wins over a simultaneous CPU write edge.
                if (!load_start && cpu_we && !we_old_q) begin
                    wr_en_s   = 1'b1;
                    wr_addr_s = cpu_addr;
                    wr_data_s = cpu_wdata;
                end else begin
                    wr_en_s   = 1'b0;
                    wr_addr_s = ptr_q;
                    wr_data_s = {DATA_W{1'b0}};
                end
            end
            ST_LOAD: begin
                if (load_valid) begin
                    wr_en_s   = 1'b1;
                    wr_addr_s = ptr_q;
                    wr_data_s = load_data;
                end else begin
                    wr_en_s   = 1'b0;
                    wr_addr_s = ptr_q;
                    wr_data_s = {DATA_W{1'b0}};
                end
            end
            default: begin
                wr_en_s   = 1'b0;
                wr_addr_s = ptr_q;
                wr_data_s = {DATA_W{1'b0}};
            end
        endcase
        if (reset) begin
            wr_en_s = 1'b0;
        end else begin
            wr_en_s = wr_en_s;
        end
    end

    // Storage array; never reset, only written through the arbitrated port.
    always_ff @(posedge clk_qzt) begin
        if (wr_en_s) begin
            mem_q[wr_addr_s] <= wr_data_s;
        end
    end

    // Control FSM with registered read data and completion pulse.
    always_ff @(posedge clk_qzt) begin
        if (reset) begin
            state_q     <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
            ptr_q       <= {ADDR_W{1'b0}};
            remaining_q <= REM_ZERO;
            we_old_q    <= 1'b0;
            cpu_rdata_q <= {DATA_W{1'b0}};
            dbg_data_q  <= {DATA_W{1'b0}};
            load_done_q <= 1'b0;
        end else begin
            we_old_q    <= cpu_we;
            dbg_data_q  <= mem_q[dbg_addr];
            load_done_q <= 1'b0;
            case (state_q)
                ST_CLEAR: begin
                    if (ptr_q == PTR_LAST) begin
                        ptr_q   <= {ADDR_W{1'b0}};
                        state_q <= ST_IDLE;
                    end else begin
                        ptr_q <= ptr_q + PTR_ONE;
                    end
                end
                ST_IDLE: begin
                    cpu_rdata_q <= mem_q[cpu_addr];
                    if (load_start) begin
                        if (load_len != REM_ZERO) begin
                            ptr_q       <= load_base;
                            remaining_q <= load_len;
                            state_q     <= ST_LOAD;
                        end else begin
                            load_done_q <= 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    if (load_valid) begin
                        ptr_q       <= ptr_q + PTR_ONE;
                        remaining_q <= remaining_q - REM_ONE;
                        if (remaining_q == REM_ONE) begin
                            state_q     <= ST_IDLE;
                            load_done_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_responder.sv
// Directed bench: instance A clears on reset, instance B retains contents;
// both share stimulus except for their resets.
module tb_ram_responder;

    logic        clk_qzt = 1'b0;
    logic        reset_a, reset_b;
    logic [7:0]  cpu_addr, cpu_wdata, load_base, load_data, dbg_addr;
    logic        cpu_we, load_start, load_valid;
    logic [8:0]  load_len;

    logic [7:0]  cpu_rdata_a, dbg_data_a, cpu_rdata_b, dbg_data_b;
    logic        cpu_hold_a, load_ready_a, load_done_a;
    logic        cpu_hold_b, load_ready_b, load_done_b;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk_qzt = ~clk_qzt;

    ram_responder #(.ADDR_W(8), .DATA_W(8), .CLEAR_ON_RESET(1'b1)) dut_a (
        .clk_qzt(clk_qzt), .reset(reset_a),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we),
        .cpu_rdata(cpu_rdata_a), .cpu_hold(cpu_hold_a),
        .load_start(load_start), .load_base(load_base), .load_len(load_len),
        .load_valid(load_valid), .load_data(load_data),
        .load_ready(load_ready_a), .load_done(load_done_a),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data_a)
    );

    ram_responder #(.ADDR_W(8), .DATA_W(8), .CLEAR_ON_RESET(1'b0)) dut_b (
        .clk_qzt(clk_qzt), .reset(reset_b),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we),
        .cpu_rdata(cpu_rdata_b), .cpu_hold(cpu_hold_b),
        .load_start(load_start), .load_base(load_base), .load_len(load_len),
        .load_valid(load_valid), .load_data(load_data),
        .load_ready(load_ready_b), .load_done(load_done_b),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge clk_qzt);
        @(negedge clk_qzt);
    endtask

    task automatic count_hold_a(input string tag);
        int cnt = 0;
        while (cpu_hold_a && cnt < 1000) begin
            tick();
            cnt++;
        end
        check(tag, cnt, 256);
    endtask

    task automatic dbg_a(input string tag, input logic [7:0] addr, input logic [7:0] exp);
        dbg_addr = addr;
        tick();
        check(tag, dbg_data_a, exp);
    endtask

    task automatic dbg_b(input string tag, input logic [7:0] addr, input logic [7:0] exp);
        dbg_addr = addr;
        tick();
        check(tag, dbg_data_b, exp);
    endtask

    task automatic cpu_write(input logic [7:0] addr, input logic [7:0] data);
        cpu_addr  = addr;
        cpu_wdata = data;
        cpu_we    = 1'b1;
        tick();
        cpu_we    = 1'b0;
        tick();
    endtask

    task automatic start_load(input logic [7:0] base, input logic [8:0] len);
        load_start = 1'b1;
        load_base  = base;
        load_len   = len;
        tick();
        load_start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] d);
        load_valid = 1'b1;
        load_data  = d;
        tick();
        load_valid = 1'b0;
    endtask

    initial begin
        int seen_done;
        reset_a = 1'b1; reset_b = 1'b1;
        cpu_addr = 8'h00; cpu_wdata = 8'h00; cpu_we = 1'b0;
        load_start = 1'b0; load_base = 8'h00; load_len = 9'd0;
        load_valid = 1'b0; load_data = 8'h00; dbg_addr = 8'h00;
        tick();
        tick();
        check("rst_cpu_rdata", cpu_rdata_a, 8'h00);
        check("rst_dbg_data", dbg_data_a, 8'h00);
        check("rst_load_done", load_done_a, 1'b0);
        check("rst_hold_clear", cpu_hold_a, 1'b1);
        check("rst_load_ready", load_ready_a, 1'b0);
        check("rst_hold_noclear", cpu_hold_b, 1'b0);
        reset_a = 1'b0; reset_b = 1'b0;
        count_hold_a("clear_len_first");

        // Fill whole memory with 0xAA (len = DEPTH), then clear again via reset.
        start_load(8'h00, 9'd256);
        check("fill_ready", load_ready_a, 1'b1);
        load_valid = 1'b1;
        load_data  = 8'hAA;
        repeat (256) tick();
        load_valid = 1'b0;
        check("fill_done", load_done_a, 1'b1);
        check("fill_ready_drop", load_ready_a, 1'b0);
        check("fill_hold", cpu_hold_a, 1'b0);
        dbg_a("fill_00", 8'h00, 8'hAA);
        dbg_a("fill_ff", 8'hFF, 8'hAA);
        reset_a = 1'b1;
        tick();
        reset_a = 1'b0;
        count_hold_a("clear_len_second");
        dbg_a("clr_00", 8'h00, 8'h00);
        dbg_a("clr_7f", 8'h7F, 8'h00);
        dbg_a("clr_ff", 8'hFF, 8'h00);

        // CPU reads with one-cycle latency, plus read-before-write.
        cpu_write(8'h10, 8'h3C);
        cpu_write(8'h11, 8'h5A);
        cpu_addr = 8'h10;
        tick();
        check("rd_10", cpu_rdata_a, 8'h3C);
        cpu_addr = 8'h11;
        tick();
        check("rd_11", cpu_rdata_a, 8'h5A);
        cpu_addr = 8'h12; cpu_wdata = 8'hE7; cpu_we = 1'b1;
        tick();
        check("rbw_old", cpu_rdata_a, 8'h00);
        cpu_we = 1'b0;
        tick();
        check("rbw_new", cpu_rdata_a, 8'hE7);

        // Held write enable produces only one write.
        cpu_addr = 8'h20; cpu_we = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            cpu_wdata = 8'(i);
            tick();
        end
        cpu_we = 1'b0;
        tick();
        dbg_a("we_held", 8'h20, 8'h01);
        cpu_write(8'h20, 8'h77);
        dbg_a("we_reedge", 8'h20, 8'h77);

        // Wrapping load with a two-cycle valid gap.
        start_load(8'hFE, 9'd3);
        check("ld_ready", load_ready_a, 1'b1);
        check("ld_hold", cpu_hold_a, 1'b1);
        send_byte(8'h11);
        tick();
        tick();
        check("ld_gap_ready", load_ready_a, 1'b1);
        send_byte(8'h22);
        check("ld_no_early_done", load_done_a, 1'b0);
        send_byte(8'h33);
        check("ld_done", load_done_a, 1'b1);
        check("ld_hold_low", cpu_hold_a, 1'b0);
        check("ld_ready_low", load_ready_a, 1'b0);
        tick();
        check("ld_done_pulse", load_done_a, 1'b0);
        dbg_a("ld_fe", 8'hFE, 8'h11);
        dbg_a("ld_ff", 8'hFF, 8'h22);
        dbg_a("ld_00", 8'h00, 8'h33);

        // CPU write edge during LOAD is dropped even when held past LOAD end.
        start_load(8'h60, 9'd2);
        cpu_addr = 8'h40; cpu_wdata = 8'h99; cpu_we = 1'b1;
        send_byte(8'hD1);
        send_byte(8'hD2);
        tick();
        tick();
        cpu_we = 1'b0;
        tick();
        dbg_a("we_in_load", 8'h40, 8'h00);
        dbg_a("ld2_60", 8'h60, 8'hD1);
        dbg_a("ld2_61", 8'h61, 8'hD2);

        // Zero-length load wins over a simultaneous write edge.
        cpu_addr = 8'h41; cpu_wdata = 8'h55; cpu_we = 1'b1;
        load_start = 1'b1; load_len = 9'd0;
        tick();
        load_start = 1'b0;
        check("len0_done", load_done_a, 1'b1);
        check("len0_hold", cpu_hold_a, 1'b0);
        tick();
        check("len0_pulse", load_done_a, 1'b0);
        check("len0_hold2", cpu_hold_a, 1'b0);
        cpu_we = 1'b0;
        tick();
        dbg_a("len0_wr_dropped", 8'h41, 8'h00);

        // Reset of the non-clearing instance mid-load.
        start_load(8'h50, 9'd4);
        check("abort_ready_pre", load_ready_b, 1'b1);
        send_byte(8'hC1);
        send_byte(8'hC2);
        reset_b = 1'b1;
        tick();
        reset_b = 1'b0;
        check("abort_hold", cpu_hold_b, 1'b0);
        check("abort_ready", load_ready_b, 1'b0);
        seen_done = 0;
        for (int i = 0; i < 4; i++) begin
            if (load_done_b) seen_done++;
            tick();
        end
        check("abort_no_done", seen_done, 0);
        dbg_b("abort_50", 8'h50, 8'hC1);
        dbg_b("abort_51", 8'h51, 8'hC2);
        dbg_b("abort_52", 8'h52, 8'hAA);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
